hwpe_stream_tcdm_writer: RTL
============================

Name: hwpe_stream_tcdm_writer

Overview:
Stream-to-memory writer, the write-direction counterpart of the TCDM source. Consumes a DATA_WIDTH hwpe stream and splits each beat into NB_TCDM_PORTS 32-bit TCDM store requests. Stores go to a strided address sequence programmed per job. Sits at the output end of an HWPE datapath and reports job completion to the controller.

Parameters:
DATA_WIDTH, 32, stream data width; must be a multiple of 32
NB_TCDM_PORTS, DATA_WIDTH/32, number of 32-bit TCDM master ports
CNT_WIDTH, 16, width of the beat counter and the trans_size field

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous reset, active-low
test_mode_i  input  1  test mode; no functional effect
clear_i  input  1  synchronous soft clear
tcdm  hwpe_stream_intf_tcdm.master  [NB_TCDM_PORTS-1:0]  store ports
stream  hwpe_stream_intf_stream.sink  DATA_WIDTH  input data stream
ctrl_i  input  ctrl_tcdm_writer_t  req_start, base_addr[31:0], stride[31:0] (bytes), trans_size[CNT_WIDTH-1:0] (beats)
flags_o  output  flags_tcdm_writer_t  ready_start, done, in_progress, beat_cnt[CNT_WIDTH-1:0]

Behaviour:
- Reset / clear: rst_ni low is asynchronous; clear_i high is synchronous at the clock edge. Both force state IDLE and zero addr, cnt, the granted mask and done. No done pulse is produced. A clear during WORKING abandons the job; requests drop in the same cycle.
- Reset output values: all tcdm req=0, stream.ready=0, flags_o.ready_start=1, done=0, in_progress=0, beat_cnt=0.
- States: IDLE and WORKING.
- IDLE:
  - ready_start=1; no TCDM requests; stream.ready=0.
  - On req_start, latch base_addr, stride and trans_size; set addr<=base_addr, cnt<=0.
  - If trans_size!=0, go to WORKING.
  - If trans_size==0, stay IDLE and pulse done the next cycle.
- WORKING (in_progress=1, ready_start=0; req_start is ignored):
  - Port ii: req = stream.valid & ~granted[ii].
  - Port ii: add = addr + 4*ii, wen=0 (write), be=4'hF, data = stream.data[32*ii +: 32].
  - granted[ii] is set at the edge where req&gnt on port ii. Each port issues exactly one store per beat, even when grants arrive in different cycles.
  - beat_done = stream.valid & &(granted | (req & gnt)).
  - stream.ready = beat_done, combinational. The stream upstream holds valid and data stable until ready.
  - On beat_done: granted<=0, addr<=addr+stride (32-bit, wraps modulo 2^32), cnt<=cnt+1.
  - If cnt==trans_size-1 on beat_done, go to IDLE. done is registered, high exactly one cycle, the cycle after the last beat is accepted. ready_start returns to 1 in that same cycle.
- General rules:
  - stream.valid low with a partial granted mask: hold the mask; no new requests.
  - tcdm r_valid and r_data are ignored.
  - beat_cnt = cnt.
  - Latency from stream.valid to TCDM req: 0 cycles.
  - Throughput: 1 beat/cycle when all ports grant.

Optional Feature:
HWPE_STREAM_TCDM_WRITER_PERF_EN
- Defined: adds flags_o.stall_cnt[31:0].
  - Increments each WORKING cycle with stream.valid=1 and beat_done=0.
  - Zeroed on req_start, reset and clear_i.
  - Saturates at 32'hFFFFFFFF.
- Undefined: the field is absent from flags_tcdm_writer_t and no counter logic exists.

Decomposition:
- hwpe_stream_package holds ctrl_tcdm_writer_t, flags_tcdm_writer_t (with the stall_cnt field under the same macro) and the state enum. Add TCDM_WRITER_IDLE and TCDM_WRITER_WORKING as new states; do not reuse the source enum.
- One sub-module: hwpe_stream_tcdm_writer_addrgen, holding addr/cnt registers, stride add, last-beat compare, and enable/clear inputs.
- Port splitting, grant tracking and the FSM stay in the top.

Test Plan:
1. NB_TCDM_PORTS=2, base=0x1000, stride=8, trans_size=4, always-grant, continuous valid -> stores at 0x1000/0x1004, 0x1008/0x100C, 0x1010/0x1014, 0x1018/0x101C in 4 consecutive cycles; done high exactly in cycle 5.
2. Same job; port 1 gnt delayed 2 cycles on beat 0 -> port 0 req drops after its grant; port 1 holds req with the same add/data; stream.ready on the cycle of port 1's grant only; no duplicate stores.
3. valid toggled 1-0-1 per cycle, trans_size=3 -> 3 beats accepted; addr advances only on accepted beats; done after the 3rd.
4. trans_size=0 with req_start -> no TCDM req ever; done pulses 1 cycle later; FSM remains IDLE.
5. clear_i asserted after beat 1 of 4 -> requests drop in that cycle; IDLE and ready_start=1 next cycle; no done; a new job then starts from its own base.
6. base=0xFFFFFFF8, stride=8, trans_size=2 -> second beat at 0x00000000; with PERF_EN and 3 stalled cycles, stall_cnt=3 at done.

Source files
------------

// File: rtl/hwpe_stream_package.sv
// -----------------------------------------------------------------------------
// hwpe_stream_package
// Shared types for the TCDM stream writer: the control and flag structs
// exchanged with the HWPE controller, and the writer's FSM state encoding.
//
// Configuration macro: HWPE_STREAM_TCDM_WRITER_PERF_EN
//   When defined, flags_tcdm_writer_t carries a 32-bit stall counter.
// -----------------------------------------------------------------------------
package hwpe_stream_package;

  localparam int unsigned TCDM_WRITER_CNT_WIDTH = 16;

  typedef enum logic {
    TCDM_WRITER_IDLE    = 1'b0,
    TCDM_WRITER_WORKING = 1'b1
  } tcdm_writer_state_e;

  typedef struct packed {
    logic                             req_start;
    logic [31:0]                      base_addr;
    logic [31:0]                      stride;      // bytes between beats
    logic [TCDM_WRITER_CNT_WIDTH-1:0] trans_size;  // beats per job
  } ctrl_tcdm_writer_t;

  typedef struct packed {
    logic                             ready_start;
    logic                             done;
    logic                             in_progress;
    logic [TCDM_WRITER_CNT_WIDTH-1:0] beat_cnt;
`ifdef HWPE_STREAM_TCDM_WRITER_PERF_EN
    logic [31:0]                      stall_cnt;
`endif
  } flags_tcdm_writer_t;

endpackage

// File: rtl/hwpe_stream_interfaces.sv
// -----------------------------------------------------------------------------
// hwpe_stream_intf_tcdm / hwpe_stream_intf_stream
// Minimal bus bundles used by the TCDM writer.
//   hwpe_stream_intf_tcdm   : one 32-bit TCDM port (req/gnt handshake, store
//                             fields, read response fields).
//   hwpe_stream_intf_stream : valid/ready stream of DATA_WIDTH bits.
// -----------------------------------------------------------------------------
interface hwpe_stream_intf_tcdm;
  logic        req;
  logic        gnt;
  logic [31:0] add;
  logic        wen;     // 0 = write
  logic [3:0]  be;
  logic [31:0] data;
  logic [31:0] r_data;
  logic        r_valid;

  modport master (output req, add, wen, be, data, input gnt, r_data, r_valid);
  modport slave  (input req, add, wen, be, data, output gnt, r_data, r_valid);
endinterface

interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;

  modport source (output valid, data, input ready);
  modport sink   (input valid, data, output ready);
endinterface

// File: rtl/hwpe_stream_tcdm_writer_addrgen.sv
// -----------------------------------------------------------------------------
// hwpe_stream_tcdm_writer_addrgen
// Strided address and beat counter for the TCDM writer.
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   clear_i        : synchronous clear of address and counter
//   i_start        : load base address, stride and job length
//   i_base_addr    : first beat address
//   i_stride       : byte increment per accepted beat
//   i_trans_size   : job length in beats
//   i_en           : a beat was accepted this cycle
//   o_addr         : address of the current beat
//   o_cnt          : beats accepted so far
//   o_last         : current beat is the final one of the job
// -----------------------------------------------------------------------------
module hwpe_stream_tcdm_writer_addrgen #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 i_start,
  input  logic [31:0]          i_base_addr,
  input  logic [31:0]          i_stride,
  input  logic [CNT_WIDTH-1:0] i_trans_size,
  input  logic                 i_en,
  output logic [31:0]          o_addr,
  output logic [CNT_WIDTH-1:0] o_cnt,
  output logic                 o_last
);

  logic [31:0]          r_addr;
  logic [31:0]          r_stride;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] r_trans_size;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_addr       <= '0;
      r_stride     <= '0;
      r_cnt        <= '0;
      r_trans_size <= '0;
    end else if (clear_i) begin
      r_addr       <= '0;
      r_stride     <= '0;
      r_cnt        <= '0;
      r_trans_size <= '0;
    end else if (i_start) begin
      r_addr       <= i_base_addr;
      r_stride     <= i_stride;
      r_cnt        <= '0;
      r_trans_size <= i_trans_size;
    end else if (i_en) begin
      r_addr <= r_addr + r_stride;  // wraps modulo 2^32
      r_cnt  <= r_cnt + CNT_WIDTH'(1);
    end
  end

  assign o_addr = r_addr;
  assign o_cnt  = r_cnt;
  assign o_last = (r_cnt == r_trans_size - CNT_WIDTH'(1));

endmodule

// File: rtl/hwpe_stream_tcdm_writer.sv
// -----------------------------------------------------------------------------
// hwpe_stream_tcdm_writer
// Consumes a DATA_WIDTH stream and stores each beat as NB_TCDM_PORTS 32-bit
// TCDM writes at a strided address sequence; reports job completion.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   test_mode_i   : test mode (no functional effect)
//   clear_i       : synchronous soft clear, abandons any running job
//   tcdm[]        : 32-bit TCDM store master ports
//   stream        : input data stream (sink)
//   ctrl_i        : job programming (req_start, base_addr, stride, trans_size)
//   flags_o       : ready_start, done, in_progress, beat_cnt
//
// Configuration macro: HWPE_STREAM_TCDM_WRITER_PERF_EN
//   When defined, flags_o.stall_cnt counts WORKING cycles with valid data
//   that could not complete a beat (saturating).
// -----------------------------------------------------------------------------
module hwpe_stream_tcdm_writer
  import hwpe_stream_package::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned NB_TCDM_PORTS = DATA_WIDTH / 32,
  parameter int unsigned CNT_WIDTH     = TCDM_WRITER_CNT_WIDTH
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        test_mode_i,
  input  logic                        clear_i,
  hwpe_stream_intf_tcdm.master        tcdm [NB_TCDM_PORTS-1:0],
  hwpe_stream_intf_stream.sink        stream,
  input  ctrl_tcdm_writer_t           ctrl_i,
  output flags_tcdm_writer_t          flags_o
);

  tcdm_writer_state_e       r_state, w_state_next;
  logic [NB_TCDM_PORTS-1:0] r_granted;
  logic [NB_TCDM_PORTS-1:0] w_req;
  logic [NB_TCDM_PORTS-1:0] w_gnt;
  logic                     r_done, w_done_next;
  logic                     w_start;
  logic                     w_working;
  logic                     w_beat_done;
  logic [31:0]              w_addr;
  logic [CNT_WIDTH-1:0]     w_cnt;
  logic                     w_last;
  logic                     w_unused_test;

  assign w_unused_test = test_mode_i;

  // Clear drops requests and blocks beat acceptance in the same cycle.
  assign w_working = (r_state == TCDM_WRITER_WORKING) && !clear_i;

  // Ports already granted for this beat stay quiet until the whole beat lands,
  // so each port issues exactly one store per beat.
  assign w_req       = (w_working && stream.valid) ? ~r_granted : '0;
  assign w_beat_done = w_working && stream.valid && (&(r_granted | (w_req & w_gnt)));
  assign stream.ready = w_beat_done;

  for (genvar ii = 0; ii < NB_TCDM_PORTS; ii++) begin : gen_port
    logic w_unused_rsp;
    assign w_gnt[ii]      = tcdm[ii].gnt;
    assign tcdm[ii].req   = w_req[ii];
    assign tcdm[ii].add   = w_addr + 32'(4 * ii);
    assign tcdm[ii].wen   = 1'b0;
    assign tcdm[ii].be    = 4'hF;
    assign tcdm[ii].data  = stream.data[32*ii +: 32];
    assign w_unused_rsp   = tcdm[ii].r_valid ^ (^tcdm[ii].r_data);
  end

  hwpe_stream_tcdm_writer_addrgen #(
    .CNT_WIDTH (CNT_WIDTH)
  ) i_addrgen (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .clear_i      (clear_i),
    .i_start      (w_start),
    .i_base_addr  (ctrl_i.base_addr),
    .i_stride     (ctrl_i.stride),
    .i_trans_size (ctrl_i.trans_size),
    .i_en         (w_beat_done),
    .o_addr       (w_addr),
    .o_cnt        (w_cnt),
    .o_last       (w_last)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_done_next  = 1'b0;
    w_start      = 1'b0;
    case (r_state)
      TCDM_WRITER_IDLE: begin
        if (ctrl_i.req_start) begin
          w_start = 1'b1;
          if (ctrl_i.trans_size != '0) w_state_next = TCDM_WRITER_WORKING;
          else                         w_done_next  = 1'b1;
        end
      end
      TCDM_WRITER_WORKING: begin
        if (w_beat_done && w_last) begin
          w_state_next = TCDM_WRITER_IDLE;
          w_done_next  = 1'b1;
        end
      end
      default: w_state_next = TCDM_WRITER_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= TCDM_WRITER_IDLE;
      r_done    <= 1'b0;
      r_granted <= '0;
    end else if (clear_i) begin
      r_state   <= TCDM_WRITER_IDLE;
      r_done    <= 1'b0;
      r_granted <= '0;
    end else begin
      r_state <= w_state_next;
      r_done  <= w_done_next;
      if (r_state == TCDM_WRITER_WORKING) begin
        if (w_beat_done) r_granted <= '0;
        else             r_granted <= r_granted | (w_req & w_gnt);
      end
    end
  end

`ifdef HWPE_STREAM_TCDM_WRITER_PERF_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stall_cnt <= '0;
    end else if (clear_i || w_start) begin
      r_stall_cnt <= '0;
    end else if (w_working && stream.valid && !w_beat_done && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end
`endif

  always_comb begin
    flags_o             = '0;
    flags_o.ready_start = (r_state == TCDM_WRITER_IDLE);
    flags_o.done        = r_done;
    flags_o.in_progress = (r_state == TCDM_WRITER_WORKING);
    flags_o.beat_cnt    = w_cnt;
`ifdef HWPE_STREAM_TCDM_WRITER_PERF_EN
    flags_o.stall_cnt   = r_stall_cnt;
`endif
  end

endmodule
